// File: rtl/datamem_stream_ctrl_if.sv
// Bundle of command, byte-stream and memory-port signals around the burst controller.
// A transfer on any valid/ready pair happens on a rising edge where both are high; the
// producer holds valid and its payload steady until that edge.
interface datamem_stream_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    logic              busy;
    logic              done;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // slave: the burst controller; master: the datapath/memory environment around it
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, mem_en, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, mem_en, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/datamem_stream_ctrl.sv
// Burst master for the 256x8 data memory: moves one byte per cycle between the memory
// ports and the write/read byte streams, under a valid/ready burst command.
module datamem_stream_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    datamem_stream_ctrl_if.slave   bus,
    output logic [2:0]             dbg_state_o
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]        remaining_q, remaining_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              wr_beat;
    logic              rd_load;
    logic              last_beat;

    assign wr_beat   = (state_q == ST_WRITE) && bus.wr_valid;
    // The output register refills whenever it is empty or being drained this cycle.
    assign rd_load   = (state_q == ST_READ) && (!rd_valid_q || bus.rd_ready);
    assign last_beat = (remaining_q == 9'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
                    state_d     = bus.cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_beat) begin
                    cur_addr_d  = cur_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - 9'd1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (rd_load) begin
                    rd_data_d   = bus.mem_rdata;
                    rd_valid_d  = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - 9'd1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_valid_q && bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-side strobes are gated by rst so an abort never lands a byte in memory.
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.wr_ready  = (state_q == ST_WRITE) && !rst;
    assign bus.mem_en    = wr_beat && !rst;
    assign bus.mem_waddr = cur_addr_q;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.mem_raddr = cur_addr_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign dbg_state_o   = state_q;

    a_rd_stable: assert property (@(posedge clk) disable iff (rst)
        (rd_valid_q && !bus.rd_ready) |=> (rd_valid_q && $stable(rd_data_q)));

    a_mem_en_in_write: assert property (@(posedge clk) disable iff (rst)
        bus.mem_en |-> (state_q == ST_WRITE));

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);
endmodule

// File: tb/tb_datamem_stream_ctrl.sv
// Directed bench for datamem_stream_ctrl with a 256x8 memory model and per-scenario tasks.
module tb_datamem_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    datamem_stream_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    datamem_stream_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // memory model: synchronous write, combinational read
    logic [7:0] mem [256] = '{default: 8'h00};
    int         wr_count = 0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
            wr_count           <= wr_count + 1;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_raddr];

    int errors = 0;
    int checks = 0;

    logic [7:0] wq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int w_en_cnt, w_en_bad, w_done_cnt, w_done_cyc;
    int r_unstable, r_done_cnt, r_done_cyc, r_first_valid, r_stalls, r_en_seen;

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        #1;
        while (!bus.cmd_ready) begin
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL cmd_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
                break;
            end
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [7:0] len_raw,
                               input int beats, input logic [15:0] pat);
        int beat, cyc, post;
        beat = 0; cyc = 0; post = -1;
        w_en_cnt = 0; w_en_bad = 0; w_done_cnt = 0; w_done_cyc = -1;
        issue_cmd(1'b1, addr, len_raw);
        while (post != 0) begin
            if (cyc > beats + 40) begin
                checks++;
                errors++;
                $display("FAIL write_timeout: beats=%0d required %0d", beat, beats);
                break;
            end
            bus.wr_valid = (beat < beats) && ((cyc >= 16) ? 1'b1 : pat[cyc[3:0]]);
            bus.wr_data  = (beat < beats) ? wq[beat] : 8'h00;
            #1;
            if (bus.mem_en !== bus.wr_valid) w_en_bad++;
            if (bus.mem_en === 1'b1) w_en_cnt++;
            if (bus.wr_valid && bus.wr_ready) beat++;
            if (bus.done === 1'b1) begin
                w_done_cnt++;
                if (w_done_cyc < 0) w_done_cyc = cyc;
                if (post < 0) post = 3;
            end
            if (post > 0) post--;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [7:0] len_raw,
                              input int beats, input logic [15:0] pat);
        int         cyc, post;
        logic       prev_stall;
        logic [7:0] prev_data;
        cyc = 0; post = -1; prev_stall = 1'b0; prev_data = 8'h00;
        got_q.delete();
        r_unstable = 0; r_done_cnt = 0; r_done_cyc = -1; r_first_valid = -1;
        r_stalls = 0; r_en_seen = 0;
        issue_cmd(1'b0, addr, len_raw);
        while (post != 0) begin
            if (cyc > beats + 40) begin
                checks++;
                errors++;
                $display("FAIL read_timeout: got %0d bytes required %0d", got_q.size(), beats);
                break;
            end
            bus.rd_ready = (cyc >= 16) ? 1'b1 : pat[cyc[3:0]];
            #1;
            if (prev_stall && (bus.rd_data !== prev_data)) r_unstable++;
            if ((bus.rd_valid === 1'b1) && (r_first_valid < 0)) r_first_valid = cyc;
            if (bus.mem_en === 1'b1) r_en_seen++;
            if (bus.rd_valid && bus.rd_ready) got_q.push_back(bus.rd_data);
            if (bus.rd_valid && !bus.rd_ready) r_stalls++;
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_data  = bus.rd_data;
            if (bus.done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
                if (post < 0) post = 3;
            end
            if (post > 0) post--;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.rd_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0b required 0", bus.mem_en); end
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0b required 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %0b required 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %0h required 00", bus.rd_data); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b required 0", bus.done); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %0b required 0", bus.wr_ready); end
        checks++; if (bus.mem_raddr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %0h required 00", bus.mem_raddr); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_burst();
        int base;
        base = wr_count;
        wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        write_burst(8'h10, 8'd4, 4, 16'hFFFF);
        checks++; if (w_en_cnt !== 4) begin errors++; $display("FAIL wr_en_cycles: got %0d required 4", w_en_cnt); end
        checks++; if (w_en_bad !== 0) begin errors++; $display("FAIL wr_en_gating: got %0d bad cycles required 0", w_en_bad); end
        checks++; if (w_done_cnt !== 1) begin errors++; $display("FAIL wr_done_count: got %0d required 1", w_done_cnt); end
        checks++; if (w_done_cyc !== 4) begin errors++; $display("FAIL wr_done_cycle: got %0d required 4", w_done_cyc); end
        checks++; if (wr_count - base !== 4) begin errors++; $display("FAIL wr_count: got %0d required 4", wr_count - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[8'h10 + i] !== wq[i]) begin
                errors++; $display("FAIL wr_mem[%0h]: got %0h required %0h", 8'h10 + i, mem[8'h10 + i], wq[i]);
            end
        end
        checks++; if (mem[8'h14] !== 8'h00) begin errors++; $display("FAIL wr_mem_past_end: got %0h required 00", mem[8'h14]); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_after: got %0b required 1", bus.cmd_ready); end
    endtask

    task automatic test_read_burst();
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        read_burst(8'h10, 8'd4, 4, 16'hFFFF);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL rd_count: got %0d required 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rd_byte%0d: got %0h required %0h", i, g, exp_q[i]); end
        end
        checks++; if (r_first_valid !== 1) begin errors++; $display("FAIL rd_first_valid: got %0d required 1", r_first_valid); end
        checks++; if (r_done_cyc !== 5) begin errors++; $display("FAIL rd_done_cycle: got %0d required 5", r_done_cyc); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL rd_done_count: got %0d required 1", r_done_cnt); end
        checks++; if (r_en_seen !== 0) begin errors++; $display("FAIL rd_no_write: got %0d required 0", r_en_seen); end
    endtask

    task automatic test_wrap();
        wq = '{8'h11, 8'h22, 8'h33};
        write_burst(8'hFE, 8'd3, 3, 16'hFFFF);
        checks++; if (mem[8'hFE] !== 8'h11) begin errors++; $display("FAIL wrap_mem_fe: got %0h required 11", mem[8'hFE]); end
        checks++; if (mem[8'hFF] !== 8'h22) begin errors++; $display("FAIL wrap_mem_ff: got %0h required 22", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 8'h33) begin errors++; $display("FAIL wrap_mem_00: got %0h required 33", mem[8'h00]); end
        exp_q = '{8'h11, 8'h22, 8'h33};
        read_burst(8'hFE, 8'd3, 3, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL wrap_rd%0d: got %0h required %0h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        // rd_ready 1,0,0,1,1 then high
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        read_burst(8'h10, 8'd3, 3, 16'hFFF9);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_rd_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL bp_rd%0d: got %0h required %0h", i, g, exp_q[i]); end
        end
        checks++; if (r_unstable !== 0) begin errors++; $display("FAIL bp_rd_stable: got %0d changes required 0", r_unstable); end
        checks++; if (r_stalls !== 2) begin errors++; $display("FAIL bp_rd_stalls: got %0d required 2", r_stalls); end
        checks++; if (r_done_cyc !== 6) begin errors++; $display("FAIL bp_rd_done_cycle: got %0d required 6", r_done_cyc); end
        // wr_valid 1,0,1,0,0,1
        wq = '{8'h55, 8'h66, 8'h77};
        write_burst(8'h80, 8'd3, 3, 16'hFFE5);
        checks++; if (w_en_bad !== 0) begin errors++; $display("FAIL bp_wr_en_gating: got %0d bad cycles required 0", w_en_bad); end
        checks++; if (w_en_cnt !== 3) begin errors++; $display("FAIL bp_wr_en_cycles: got %0d required 3", w_en_cnt); end
        checks++; if (w_done_cyc !== 6) begin errors++; $display("FAIL bp_wr_done_cycle: got %0d required 6", w_done_cyc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[8'h80 + i] !== wq[i]) begin
                errors++; $display("FAIL bp_wr_mem[%0h]: got %0h required %0h", 8'h80 + i, mem[8'h80 + i], wq[i]);
            end
        end
    endtask

    task automatic test_len0();
        int base, bad;
        logic [7:0] a;
        base = wr_count;
        wq.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            wq.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        write_burst(8'h40, 8'd0, 256, 16'hFFFF);
        checks++; if (w_en_cnt !== 256) begin errors++; $display("FAIL len0_wr_en: got %0d required 256", w_en_cnt); end
        checks++; if (wr_count - base !== 256) begin errors++; $display("FAIL len0_wr_count: got %0d required 256", wr_count - base); end
        checks++; if (w_done_cnt !== 1) begin errors++; $display("FAIL len0_wr_done: got %0d required 1", w_done_cnt); end
        checks++; if (w_done_cyc !== 256) begin errors++; $display("FAIL len0_wr_done_cycle: got %0d required 256", w_done_cyc); end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            a = 8'h40 + 8'(i);
            if (mem[a] !== 8'(i)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL len0_mem: got %0d wrong locations required 0", bad); end
        read_burst(8'h40, 8'd0, 256, 16'hFFFF);
        checks++; if (got_q.size() !== 256) begin errors++; $display("FAIL len0_rd_count: got %0d required 256", got_q.size()); end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if ((i >= got_q.size()) || (got_q[i] !== exp_q[i])) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL len0_rd_data: got %0d wrong bytes required 0", bad); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL len0_rd_done: got %0d required 1", r_done_cnt); end
        checks++; if (r_done_cyc !== 257) begin errors++; $display("FAIL len0_rd_done_cycle: got %0d required 257", r_done_cyc); end
    endtask

    task automatic test_reset_mid_write();
        int base;
        base = wr_count;
        // after the len-0 burst, 0x20..0x23 hold E0..E3
        issue_cmd(1'b1, 8'h20, 8'd4);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hC1;
        @(posedge clk); #1;
        bus.wr_data  = 8'hC2;
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.wr_data  = 8'hC3;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_en: got %0b required 0", bus.mem_en); end
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready: got %0b required 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b required 0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_valid: got %0b required 0", bus.rd_valid); end
        checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL mid_rst_writes: got %0d required 2", wr_count - base); end
        checks++; if (mem[8'h20] !== 8'hC1) begin errors++; $display("FAIL mid_rst_mem20: got %0h required c1", mem[8'h20]); end
        checks++; if (mem[8'h21] !== 8'hC2) begin errors++; $display("FAIL mid_rst_mem21: got %0h required c2", mem[8'h21]); end
        checks++; if (mem[8'h22] !== 8'hE2) begin errors++; $display("FAIL mid_rst_mem22: got %0h required e2", mem[8'h22]); end
        checks++; if (mem[8'h23] !== 8'hE3) begin errors++; $display("FAIL mid_rst_mem23: got %0h required e3", mem[8'h23]); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_len   = 8'h00;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.rd_ready  = 1'b1;

        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_backpressure();
        test_len0();
        test_reset_mid_write();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
